rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter_if.sv | 35 +++
 rtl/rf_write_arbiter.sv | 49 ++++
 tb/tb_rf_write_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: requester, freeze, read-address and register-file write bus of the write arbiter
//   req0_*/req1_*  : valid/addr/data in, ready out (0 = ALU writeback, 1 = memory-load writeback)
//   hold           : controller freeze, no register-file write while high
//   ra1/ra2        : read addresses currently presented to the register file
//   we/wa3/wd3     : register-file write port
//   haz1/haz2      : read address matches the staged, uncommitted write
interface rf_write_arbiter_if #(
    parameter int AW = 3,
    parameter int DW = 16
);
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          hold;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          we;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3;
    logic          haz1;
    logic          haz2;
    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, hold, ra1, ra2,
        output req0_ready, req1_ready, we, wa3, wd3, haz1, haz2
    );
    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, hold, ra1, ra2,
        input  req0_ready, req1_ready, we, wa3, wd3, haz1, haz2
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two-requester register-file write arbiter with a one-entry stage and read hazard flags
//   clk_i : clock, all state updates on the rising edge
//   rst_i : synchronous active-high reset, discards any staged write
//   bus   : rf_write_arbiter_if slave (requesters, hold, read addresses, write port, hazard flags)
module rf_write_arbiter #(
    parameter int AW = 3,
    parameter int DW = 16
) (
    input logic clk_i,
    input logic rst_i,
    rf_write_arbiter_if.slave bus
);
    logic          sv_q, sv_d, prio_q, prio_d;
    logic [AW-1:0] sa_q, sa_d;
    logic [DW-1:0] sd_q, sd_d;
    logic          free, win0, win1, acc;
    always_comb begin
        // stage can take a new write when empty or when its entry commits this cycle
        free = !sv_q || !bus.hold;
        win0 = bus.req0_valid && (!bus.req1_valid || !prio_q);
        win1 = bus.req1_valid && (!bus.req0_valid || prio_q);
        bus.req0_ready = win0 && free && !rst_i;
        bus.req1_ready = win1 && free && !rst_i;
        acc = bus.req0_ready || bus.req1_ready;
        sv_d = acc || (sv_q && bus.hold);
        sa_d = acc ? (win1 ? bus.req1_addr : bus.req0_addr) : sa_q;
        sd_d = acc ? (win1 ? bus.req1_data : bus.req0_data) : sd_q;
        // the requester just served loses preference
        prio_d = acc ? win0 : prio_q;
    end
    assign bus.we   = sv_q && !bus.hold;
    assign bus.wa3  = sa_q;
    assign bus.wd3  = sd_q;
    assign bus.haz1 = sv_q && (bus.ra1 == sa_q);
    assign bus.haz2 = sv_q && (bus.ra2 == sa_q);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sv_q   <= 1'b0;
            sa_q   <= '0;
            sd_q   <= '0;
            prio_q <= 1'b0;
        end else begin
            sv_q   <= sv_d;
            sa_q   <= sa_d;
            sd_q   <= sd_d;
            prio_q <= prio_d;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed and randomized checks of rf_write_arbiter against a queue-based model
module tb_rf_write_arbiter;
    localparam int AW = 3;
    localparam int DW = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    rf_write_arbiter_if #(.AW(AW), .DW(DW)) b ();
    rf_write_arbiter #(.AW(AW), .DW(DW)) dut (.clk_i(clk), .rst_i(rst), .bus(b.slave));
    always #5 clk = ~clk;
    logic [AW+DW-1:0] m_q[$];
    logic             m_prio = 1'b0;
    logic [AW-1:0]    m_sa = '0;
    logic [DW-1:0]    m_sd = '0;
    logic [DW-1:0]    mem[8];
    logic [DW-1:0]    rf[8];
    logic             e_r0 = 1'b0, e_r1 = 1'b0, e_we = 1'b0, e_h1, e_h2;
    logic             winner, has_winner;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask
    always @(negedge clk) begin
        #1;
        has_winner = b.req0_valid || b.req1_valid;
        winner = (b.req0_valid && b.req1_valid) ? m_prio : b.req1_valid;
        e_we = (m_q.size() != 0) && !b.hold;
        e_r0 = !rst && has_winner && !winner && (m_q.size() == 0 || !b.hold);
        e_r1 = !rst && has_winner && winner && (m_q.size() == 0 || !b.hold);
        e_h1 = (m_q.size() != 0) && (b.ra1 == m_sa);
        e_h2 = (m_q.size() != 0) && (b.ra2 == m_sa);
        chk("ready0", 32'(b.req0_ready), 32'(e_r0));
        chk("ready1", 32'(b.req1_ready), 32'(e_r1));
        chk("we", 32'(b.we), 32'(e_we));
        chk("wa3", 32'(b.wa3), 32'(m_sa));
        chk("wd3", 32'(b.wd3), 32'(m_sd));
        chk("haz1", 32'(b.haz1), 32'(e_h1));
        chk("haz2", 32'(b.haz2), 32'(e_h2));
    end
    always @(posedge clk) begin
        if (b.we) rf[b.wa3] = b.wd3;
        if (rst) begin
            m_q.delete();
            m_prio = 1'b0;
            m_sa = '0;
            m_sd = '0;
        end else begin
            if (e_we) begin
                mem[m_q[0][DW+AW-1:DW]] = m_q[0][DW-1:0];
                void'(m_q.pop_front());
            end
            if (e_r0 || e_r1) begin
                m_sa = e_r1 ? b.req1_addr : b.req0_addr;
                m_sd = e_r1 ? b.req1_data : b.req0_data;
                m_q.push_back({m_sa, m_sd});
                m_prio = e_r0;
            end
        end
        e_we = 1'b0;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
    end
    task automatic drive(input logic r, input logic h, input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        @(negedge clk);
        rst = r;
        b.hold = h;
        b.req0_valid = v0;
        b.req0_addr = a0;
        b.req0_data = d0;
        b.req1_valid = v1;
        b.req1_addr = a1;
        b.req1_data = d1;
        b.ra1 = r1;
        b.ra2 = r2;
        #2;
    endtask
    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
    endtask
    logic          p0 = 1'b0, p1 = 1'b0;
    logic [AW-1:0] pa0, pa1;
    logic [DW-1:0] pd0, pd1;
    initial begin
        for (int i = 0; i < 8; i++) begin
            mem[i] = '0;
            rf[i] = '0;
        end
        b.hold = 0; b.req0_valid = 0; b.req1_valid = 0;
        b.req0_addr = 0; b.req1_addr = 0; b.req0_data = 0; b.req1_data = 0;
        b.ra1 = 0; b.ra2 = 0;
        drive(1, 0, 1, 3, 16'h1111, 1, 4, 16'h2222, 0, 0);
        chk("rst_ready0", 32'(b.req0_ready), 0);
        chk("rst_ready1", 32'(b.req1_ready), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_we", 32'(b.we), 0);
        chk("rst_wa3", 32'(b.wa3), 0);
        chk("rst_wd3", 32'(b.wd3), 0);
        chk("rst_haz1", 32'(b.haz1), 0);
        drive(0, 0, 1, 3, 16'hBEEF, 0, 0, 0, 7, 7);
        chk("single_ready0", 32'(b.req0_ready), 1);
        idle();
        chk("single_we", 32'(b.we), 1);
        chk("single_wa3", 32'(b.wa3), 3);
        chk("single_wd3", 32'(b.wd3), 32'hBEEF);
        idle();
        chk("single_we_off", 32'(b.we), 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 7, 7);
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 1, 1, 16'h0011, 1, 2, 16'h0022, 7, 7);
            chk("cont_ready0", 32'(b.req0_ready), 32'(c % 2 == 0));
            chk("cont_ready1", 32'(b.req1_ready), 32'(c % 2 == 1));
            if (c > 0) chk("cont_wa3", 32'(b.wa3), (c % 2 == 1) ? 1 : 2);
            if (c > 0) chk("cont_we", 32'(b.we), 1);
        end
        idle();
        chk("cont_last_wa3", 32'(b.wa3), 2);
        drive(0, 0, 1, 5, 16'h1234, 0, 0, 0, 7, 7);
        chk("hold_acc", 32'(b.req0_ready), 1);
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 0, 0, 0, 1, 7, 16'h0077, 5, 0);
            chk("hold_we", 32'(b.we), 0);
            chk("hold_ready1", 32'(b.req1_ready), 0);
            chk("hold_haz1", 32'(b.haz1), 1);
        end
        drive(0, 0, 0, 0, 0, 1, 7, 16'h0077, 5, 0);
        chk("hold_fall_we", 32'(b.we), 1);
        chk("hold_fall_wa3", 32'(b.wa3), 5);
        chk("hold_fall_ready1", 32'(b.req1_ready), 1);
        idle();
        chk("hold_next_wa3", 32'(b.wa3), 7);
        idle();
        for (int c = 1; c <= 5; c++) begin
            drive(0, 0, 0, 0, 0, c <= 4, 2, 16'(c), 7, 7);
            if (c <= 4) chk("b2b_ready1", 32'(b.req1_ready), 1);
            if (c >= 2) chk("b2b_we", 32'(b.we), 1);
            if (c >= 2) chk("b2b_wd3", 32'(b.wd3), c - 1);
        end
        idle();
        drive(0, 0, 1, 6, 16'h0066, 0, 0, 0, 7, 7);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 7, 6);
        chk("rmid_haz2", 32'(b.haz2), 1);
        chk("rmid_we", 32'(b.we), 0);
        drive(1, 1, 0, 0, 0, 1, 1, 16'h0099, 7, 6);
        chk("rmid_ready1", 32'(b.req1_ready), 0);
        idle();
        chk("rmid_we_after", 32'(b.we), 0);
        chk("rmid_wa3_after", 32'(b.wa3), 0);
        drive(0, 0, 1, 1, 16'h0011, 1, 2, 16'h0022, 7, 7);
        chk("rmid_prio0", 32'(b.req0_ready), 1);
        chk("rmid_loser", 32'(b.req1_ready), 0);
        drive(0, 0, 0, 0, 0, 1, 2, 16'h0022, 7, 7);
        idle();
        idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 7, 7);
        drive(0, 0, 1, 4, 16'hAAAA, 1, 4, 16'h5555, 7, 7);
        chk("same_ready0", 32'(b.req0_ready), 1);
        drive(0, 0, 0, 0, 0, 1, 4, 16'h5555, 7, 7);
        chk("same_ready1", 32'(b.req1_ready), 1);
        chk("same_wd3_a", 32'(b.wd3), 32'hAAAA);
        idle();
        chk("same_wd3_b", 32'(b.wd3), 32'h5555);
        idle();
        chk("same_final", 32'(rf[4]), 32'h5555);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 7, 7);
        for (int c = 0; c < 3000; c++) begin
            if (!p0 && $urandom_range(1) == 1) begin
                p0 = 1; pa0 = AW'($urandom_range(7)); pd0 = DW'($urandom);
            end
            if (!p1 && $urandom_range(1) == 1) begin
                p1 = 1; pa1 = AW'($urandom_range(7)); pd1 = DW'($urandom);
            end
            drive($urandom_range(99) == 0, $urandom_range(3) == 0, p0, pa0, pd0, p1, pa1, pd1,
                  AW'($urandom_range(7)), AW'($urandom_range(7)));
            if (e_r0) p0 = 0;
            if (e_r1) p1 = 0;
        end
        idle();
        idle();
        idle();
        for (int i = 0; i < 8; i++) chk("rf_final", 32'(rf[i]), 32'(mem[i]));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
